matmul_seq: RTL and testbench

//  Parametrised sequential matrix multiplier: C[MxN] = A[MxK] * B[KxN] with one shared MAC.

---
 rtl/matmul_seq.sv | 124 ++++++++++++
 tb/tb_matmul_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// Sequential matrix multiplier C = A * B using a single shared multiply-accumulate.
// Operands are captured on the input handshake, and the result is held until the output handshake.
module matmul_seq #(
  parameter int EW     = 3,
  parameter int M      = 2,
  parameter int K      = 4,
  parameter int N      = 2,
  parameter int OW     = 2*EW + $clog2(K),
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M*K*EW-1:0]   a_flat,
  input  logic [K*N*EW-1:0]   b_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M*N*OW-1:0]   c_flat,
  output logic                busy
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [M*K*EW-1:0]   a_reg;
  logic [K*N*EW-1:0]   b_reg;
  logic [IW-1:0]       i_reg;
  logic [JW-1:0]       j_reg;
  logic [KW-1:0]       k_reg;
  logic [OW-1:0]       acc_reg;
  logic [M*N*OW-1:0]   c_reg;

  logic [EW-1:0]       a_el, b_el;
  logic [OW-1:0]       a_ext, b_ext, prod, sum;
  logic                last_i, last_j, last_k;

  assign a_el = a_reg[(int'(i_reg)*K + int'(k_reg))*EW +: EW];
  assign b_el = b_reg[(int'(k_reg)*N + int'(j_reg))*EW +: EW];

  // Operands are extended to OW before multiplying; the product modulo 2^OW is
  // identical to the full 2*EW-bit product wrapped into the accumulator.
  generate
    if (SIGNED != 0) begin : g_sext
      assign a_ext = OW'($signed(a_el));
      assign b_ext = OW'($signed(b_el));
    end else begin : g_zext
      assign a_ext = OW'(a_el);
      assign b_ext = OW'(b_el);
    end
  endgenerate

  assign prod   = a_ext * b_ext;
  assign sum    = acc_reg + prod;
  assign last_i = (i_reg == IW'(M-1));
  assign last_j = (j_reg == JW'(N-1));
  assign last_k = (k_reg == KW'(K-1));
  assign c_flat = c_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_i && last_j && last_k) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      i_reg   <= '0;
      j_reg   <= '0;
      k_reg   <= '0;
      acc_reg <= '0;
      c_reg   <= '0;
    end else if (state_reg == IDLE && in_valid) begin
      a_reg   <= a_flat;
      b_reg   <= b_flat;
      i_reg   <= '0;
      j_reg   <= '0;
      k_reg   <= '0;
      acc_reg <= '0;
    end else if (state_reg == COMPUTE) begin
      if (last_k) begin
        // Element complete: commit it and walk j, then i.
        c_reg[(int'(i_reg)*N + int'(j_reg))*OW +: OW] <= sum;
        acc_reg <= '0;
        k_reg   <= '0;
        if (last_j) begin
          j_reg <= '0;
          i_reg <= last_i ? '0 : i_reg + IW'(1);
        end else begin
          j_reg <= j_reg + JW'(1);
        end
      end else begin
        acc_reg <= sum;
        k_reg   <= k_reg + KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: default, signed and 3x2x3 instances checked against a
// loop-based matrix product model.
module tb_matmul_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: EW=3, M=2, K=4, N=2, OW=8
  logic        d_iv = 0, d_ir, d_ov, d_or = 0, d_busy;
  logic [23:0] d_a = '0, d_b = '0;
  logic [31:0] d_c;
  // Signed instance, otherwise default sizes
  logic        s_iv = 0, s_ir, s_ov, s_or = 0, s_busy;
  logic [23:0] s_a = '0, s_b = '0;
  logic [31:0] s_c;
  // 3x2 * 2x3 instance with 4-bit elements, OW=9
  logic        g_iv = 0, g_ir, g_ov, g_or = 0, g_busy;
  logic [23:0] g_a = '0, g_b = '0;
  logic [80:0] g_c;

  matmul_seq dut_d (.clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir),
    .a_flat(d_a), .b_flat(d_b), .out_valid(d_ov), .out_ready(d_or), .c_flat(d_c), .busy(d_busy));
  matmul_seq #(.SIGNED(1)) dut_s (.clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir),
    .a_flat(s_a), .b_flat(s_b), .out_valid(s_ov), .out_ready(s_or), .c_flat(s_c), .busy(s_busy));
  matmul_seq #(.EW(4), .M(3), .K(2), .N(3)) dut_g (.clk(clk), .rst_n(rst_n), .in_valid(g_iv),
    .in_ready(g_ir), .a_flat(g_a), .b_flat(g_b), .out_valid(g_ov), .out_ready(g_or),
    .c_flat(g_c), .busy(g_busy));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint elem(input logic [127:0] f, input int idx, input int ew, input bit sg);
    logic [127:0] v;
    longint u;
    v = (f >> (idx*ew)) & ((128'd1 << ew) - 128'd1);
    u = longint'(v[63:0]);
    if (sg && u >= (longint'(1) << (ew-1))) u = u - (longint'(1) << ew);
    return u;
  endfunction

  // Plain matrix product, each element wrapped to ow bits and packed row-major.
  function automatic logic [127:0] ref_mm(input logic [127:0] af, input logic [127:0] bf,
      input int m, input int k, input int n, input int ew, input int ow, input bit sg);
    logic [127:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int t = 0; t < k; t++)
          s += elem(af, i*k+t, ew, sg) * elem(bf, t*n+j, ew, sg);
        for (int bt = 0; bt < ow; bt++) r[(i*n+j)*ow + bt] = s[bt];
      end
    return r;
  endfunction

  task automatic run_d(input logic [23:0] a, input logic [23:0] b, input logic [31:0] exp,
                       input string tag);
    int lat;
    check({tag, "_in_ready"}, d_ir, 1);
    d_a = a; d_b = b; d_iv = 1;
    @(posedge clk); #1;
    d_iv = 0; d_a = 24'($urandom); d_b = 24'($urandom);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (d_ov) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, 16);
    check({tag, "_c"}, d_c, exp);
    check({tag, "_busy_done"}, d_busy, 0);
    d_or = 1;
    @(posedge clk); #1;
    d_or = 0;
    check({tag, "_ov_after_ack"}, d_ov, 0);
    check({tag, "_ir_after_ack"}, d_ir, 1);
  endtask

  task automatic run_s(input logic [23:0] a, input logic [23:0] b, input logic [31:0] exp,
                       input string tag);
    int lat;
    s_a = a; s_b = b; s_iv = 1;
    @(posedge clk); #1;
    s_iv = 0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (s_ov) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, 16);
    check({tag, "_c"}, s_c, exp);
    s_or = 1;
    @(posedge clk); #1;
    s_or = 0;
    check({tag, "_ov_after_ack"}, s_ov, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] a1, b1, ra, rb, a2, b2;
    logic [31:0] held_c;
    logic [23:0] ga [3];
    logic [23:0] gb [3];
    int cap_t [3];
    int out_t [3];
    int ncap, nout, lat;
    logic prev_busy;

    a1 = {3'd0, 3'd3, 3'd0, 3'd4, 3'd7, 3'd1, 3'd3, 3'd2};
    b1 = {3'd0, 3'd1, 3'd7, 3'd6, 3'd5, 3'd2, 3'd1, 3'd0};

    #2;
    check("rst_in_ready", d_ir, 1);
    check("rst_out_valid", d_ov, 0);
    check("rst_busy", d_busy, 0);
    check("rst_c", d_c, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Directed and random products on the default instance
    check("model_t1", ref_mm(a1, b1, 2, 4, 2, 3, 8, 0), 32'h19121813);
    run_d(a1, b1, 32'h19121813, "t1");
    run_d({8{3'd7}}, {8{3'd7}}, 32'hC4C4C4C4, "t2_sevens");
    run_d('0, '0, 32'h0, "t2_zeros");
    for (int r = 0; r < 3; r++) begin
      ra = 24'($urandom); rb = 24'($urandom);
      run_d(ra, rb, 32'(ref_mm(ra, rb, 2, 4, 2, 3, 8, 0)), $sformatf("rand_d%0d", r));
    end

    // Signed instance
    run_s({8{3'b100}}, {8{3'b011}}, 32'hD0D0D0D0, "t3_neg");
    run_s({8{3'b100}}, {8{3'b100}}, 32'h40404040, "t3_pos");
    for (int r = 0; r < 3; r++) begin
      ra = 24'($urandom); rb = 24'($urandom);
      run_s(ra, rb, 32'(ref_mm(ra, rb, 2, 4, 2, 3, 8, 1)), $sformatf("rand_s%0d", r));
    end

    // Backpressure: result held, input ignored while DONE
    d_a = a1; d_b = b1; d_iv = 1;
    @(posedge clk); #1;
    d_iv = 0;
    for (int c = 0; c < 100 && !d_ov; c++) begin @(posedge clk); #1; end
    check("t4_ov", d_ov, 1);
    held_c = d_c;
    check("t4_c", held_c, 32'h19121813);
    for (int c = 0; c < 10; c++) begin
      d_iv = c[0]; d_a = 24'($urandom); d_b = 24'($urandom);
      @(posedge clk); #1;
      check($sformatf("t4_hold_ov%0d", c), d_ov, 1);
      check($sformatf("t4_hold_c%0d", c), d_c, held_c);
      check($sformatf("t4_hold_ir%0d", c), d_ir, 0);
    end
    // Output handshake with in_valid high: only the output is consumed
    a2 = 24'($urandom); b2 = 24'($urandom);
    d_a = a2; d_b = b2; d_iv = 1; d_or = 1;
    @(posedge clk); #1;
    d_or = 0;
    check("t4_ov_low", d_ov, 0);
    check("t4_ir_idle", d_ir, 1);
    check("t4_not_busy", d_busy, 0);
    @(posedge clk); #1;
    check("t4_captured_next", d_busy, 1);
    d_iv = 0; d_a = 24'($urandom); d_b = 24'($urandom);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (d_ov) begin lat = c; break; end
    end
    check("t4_second_latency", lat, 16);
    check("t4_second_c", d_c, 32'(ref_mm(a2, b2, 2, 4, 2, 3, 8, 0)));
    d_or = 1;
    @(posedge clk); #1;
    d_or = 0;

    // Reset in the middle of COMPUTE
    d_a = a1; d_b = b1; d_iv = 1;
    @(posedge clk); #1;
    d_iv = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("t5_ov", d_ov, 0);
    check("t5_c", d_c, 0);
    check("t5_ir", d_ir, 1);
    check("t5_busy", d_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_d(a1, b1, 32'h19121813, "t5_rerun");

    // Back-to-back ops on the 3x2x3 instance
    for (int r = 0; r < 3; r++) begin ga[r] = 24'($urandom); gb[r] = 24'($urandom); end
    ncap = 0; nout = 0; prev_busy = 0;
    g_a = ga[0]; g_b = gb[0]; g_iv = 1; g_or = 1;
    for (int cyc = 1; cyc <= 200 && nout < 3; cyc++) begin
      @(posedge clk); #1;
      if (g_busy && !prev_busy && ncap < 3) begin
        cap_t[ncap] = cyc;
        ncap++;
        if (ncap < 3) begin g_a = ga[ncap]; g_b = gb[ncap]; end
        else g_iv = 0;
      end
      if (g_ov && nout < 3) begin
        check($sformatf("t6_c%0d", nout), g_c, 81'(ref_mm(ga[nout], gb[nout], 3, 2, 3, 4, 9, 0)));
        out_t[nout] = cyc;
        nout++;
      end
      prev_busy = g_busy;
    end
    g_iv = 0; g_or = 0;
    check("t6_ops_done", nout, 3);
    check("t6_caps", ncap, 3);
    if (nout == 3 && ncap == 3) begin
      check("t6_latency", out_t[0] - cap_t[0], 18);
      check("t6_cap_spacing1", cap_t[1] - cap_t[0], 20);
      check("t6_cap_spacing2", cap_t[2] - cap_t[1], 20);
      check("t6_out_spacing1", out_t[1] - out_t[0], 20);
      check("t6_out_spacing2", out_t[2] - out_t[1], 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
